// File: rtl/vga_input_decoder_if.sv
// Video capture bundle: sampled VGA input toward the decoder, frame-buffer
// write requests and lock status back from it.
interface vga_input_decoder_if #(
    parameter int DATA_W = 8
);
    logic              pixel_en;
    logic              n_hsync;
    logic              n_vsync;
    logic [DATA_W-1:0] pixel_data;
    logic              wr_en;
    logic [18:0]       wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              locked;
    logic              frame_done;
    logic              timing_error;

    // Video source / capture consumer side.
    modport master (
        output pixel_en, n_hsync, n_vsync, pixel_data,
        input  wr_en, wr_addr, wr_data, locked, frame_done, timing_error
    );

    // Decoder side.
    modport slave (
        input  pixel_en, n_hsync, n_vsync, pixel_data,
        output wr_en, wr_addr, wr_data, locked, frame_done, timing_error
    );
endinterface

// File: rtl/vga_input_decoder.sv
// Receive-side VGA decoder: recovers h/v position from active-low syncs,
// verifies frame timing and, once locked, issues linear frame-buffer writes.
module vga_input_decoder #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int DATA_W   = 8
) (
    input logic               clk,
    input logic               rst,
    vga_input_decoder_if.slave bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_TMO    = 11'(2 * H_TOTAL - 1);
    localparam logic [10:0] H_ACT_LO = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_ACT_HI = 11'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_MAX    = '1;
    localparam logic [9:0]  V_ACT_LO = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  V_ACT_HI = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [18:0] ADDR_LAST = 19'(H_ACTIVE * V_ACTIVE - 1);

    typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

    state_t      state, state_n;
    logic [10:0] hcount, hcount_n;
    logic [9:0]  vcount, vcount_n;
    logic [18:0] addr, addr_n;
    logic        h_seen;
    logic        prev_h, prev_v;
    logic        h_fall, v_fall;
    logic        line_err, tmo_err, frame_err, err;
    logic        active, wr_now, last_wr;

    // Sync edge detection, position counters and timing checks.
    always_comb begin
        h_fall    = bus.pixel_en && prev_h && !bus.n_hsync;
        v_fall    = bus.pixel_en && prev_v && !bus.n_vsync;
        hcount_n  = hcount;
        vcount_n  = vcount;
        line_err  = 1'b0;
        tmo_err   = 1'b0;
        frame_err = 1'b0;
        if (h_fall) begin
            line_err = h_seen && (hcount != H_LAST);
            hcount_n = '0;
            if (vcount != V_MAX)
                vcount_n = vcount + 10'd1;
        end else if (bus.pixel_en) begin
            // Saturate at the timeout value; reaching it is the error.
            if (hcount >= H_TMO - 11'd1) begin
                hcount_n = H_TMO;
                tmo_err  = 1'b1;
            end else begin
                hcount_n = hcount + 11'd1;
            end
        end
        // vsync edge wins over the hsync vcount increment; the check uses the
        // count of the line that just ended.
        if (v_fall) begin
            frame_err = (state != SEARCH) && (vcount != V_LAST);
            vcount_n  = '0;
        end
        err = (line_err || tmo_err || frame_err) && (state != SEARCH);
    end

    // Lock state machine: one clean vsync-to-vsync frame is required to lock.
    always_comb begin
        state_n = state;
        if (bus.pixel_en) begin
            case (state)
                SEARCH:  if (v_fall) state_n = ALIGN;
                ALIGN:   if (err) state_n = SEARCH;
                         else if (v_fall) state_n = LOCKED;
                LOCKED:  if (err) state_n = SEARCH;
                default: state_n = SEARCH;
            endcase
        end
    end

    // Write request generation for pixels inside the visible window.
    always_comb begin
        active  = (hcount_n >= H_ACT_LO) && (hcount_n <= H_ACT_HI) &&
                  (vcount_n >= V_ACT_LO) && (vcount_n <= V_ACT_HI);
        wr_now  = bus.pixel_en && (state == LOCKED) && !err && active;
        last_wr = wr_now && (addr == ADDR_LAST);
        addr_n  = addr;
        if (v_fall)
            addr_n = '0;
        else if (wr_now && (addr != ADDR_LAST))
            addr_n = addr + 19'd1;
    end

    // Timing state registers; only a pixel strobe changes counters and edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= SEARCH;
            hcount <= '0;
            vcount <= '0;
            h_seen <= 1'b0;
            prev_h <= 1'b1;
            prev_v <= 1'b1;
            addr   <= '0;
        end else begin
            state  <= state_n;
            hcount <= hcount_n;
            vcount <= vcount_n;
            addr   <= addr_n;
            if (h_fall)
                h_seen <= 1'b1;
            if (bus.pixel_en) begin
                prev_h <= bus.n_hsync;
                prev_v <= bus.n_vsync;
            end
        end
    end

    // Registered write port and status pulses, one clock after the sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.wr_en        <= 1'b0;
            bus.wr_addr      <= '0;
            bus.wr_data      <= '0;
            bus.frame_done   <= 1'b0;
            bus.timing_error <= 1'b0;
        end else begin
            bus.wr_en        <= wr_now;
            bus.frame_done   <= last_wr;
            bus.timing_error <= err;
            if (wr_now) begin
                bus.wr_addr <= addr;
                bus.wr_data <= bus.pixel_data;
            end
        end
    end

    assign bus.locked = (state == LOCKED);
endmodule
